wb_gpio_debounce: RTL and testbench

//  Parametrised Wishbone-slave GPIO peripheral for Caravel user projects.
//  - Debounces NUM_BUTTONS button inputs and latches rising edges as sticky events.
//  - Drives NUM_LEDS LEDs, each either steady or blinking from a prescaler.
//  - Sits behind the project wrapper: buttons come from io_in, leds go to io_out.

---
 rtl/wb_gpio_debounce.sv | 179 +++++++++++++++++
 tb/tb_wb_gpio_debounce.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_debounce.sv
// wb_gpio_debounce: Wishbone-slave GPIO block with debounced buttons, sticky
// rising-edge events and steady/blinking LEDs.
//
// Optional feature macro: WB_GPIO_IRQ_EN
//   defined   -> IRQ_MASK register at BASE_ADDR+0x10 and a registered irq
//   undefined -> 0x10 is unmapped and irq is tied low
//
// Register map (byte offsets from BASE_ADDR, unused bits read 0):
//   0x00 LED_OUT   RW    steady LED value
//   0x04 BTN_STATE RO    debounced button levels
//   0x08 BTN_EVENT RW1C  sticky rising-edge flags
//   0x0C LED_BLINK RW    per-LED blink enable
//   0x10 IRQ_MASK  RW    event mask (WB_GPIO_IRQ_EN only)
//
// Ports:
//   clk, reset_n         clock and synchronous active-low reset
//   i_wb_cyc/stb/we      wishbone request qualifiers
//   i_wb_addr/i_wb_data  wishbone byte address / write data
//   o_wb_ack/o_wb_data   single-cycle ack and read data (0 when not acking)
//   buttons              raw asynchronous button inputs
//   leds                 registered LED drive
//   irq                  event interrupt
module wb_gpio_debounce #(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int unsigned NUM_BUTTONS     = 3,
  parameter int unsigned NUM_LEDS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned BLINK_DIV       = 5_000_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [31:0]            i_wb_addr,
  input  logic [31:0]            i_wb_data,
  output logic                   o_wb_ack,
  output logic [31:0]            o_wb_data,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic                   irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PreW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // The count that, once incremented, reaches DEBOUNCE_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(BLINK_DIV - 1);

  logic                   ack_q;
  logic [31:0]            rdata_q;
  logic [NUM_LEDS-1:0]    led_out_q;
  logic [NUM_LEDS-1:0]    blink_q;
  logic [NUM_LEDS-1:0]    leds_q;
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] state_q, state_d;
  logic [NUM_BUTTONS-1:0] event_q, event_d;
  logic [NUM_BUTTONS-1:0] rise, clr;
  logic [CntW-1:0]        cnt_q [NUM_BUTTONS];
  logic [CntW-1:0]        cnt_d [NUM_BUTTONS];
  logic [PreW-1:0]        pre_q;
  logic                   phase_q;

  logic        req, wr;
  logic        sel_led, sel_state, sel_event, sel_blink, sel_mask;
  logic [31:0] rdata_mux;
  logic        unused_wdata;

  // A request is not accepted while its own ack is out, so a held strobe
  // is acked every second cycle.
  assign req = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr  = req & i_wb_we;

  assign sel_led   = (i_wb_addr == BASE_ADDR);
  assign sel_state = (i_wb_addr == BASE_ADDR + 32'h4);
  assign sel_event = (i_wb_addr == BASE_ADDR + 32'h8);
  assign sel_blink = (i_wb_addr == BASE_ADDR + 32'hC);

  assign unused_wdata = ^i_wb_data;

`ifdef WB_GPIO_IRQ_EN
  logic [NUM_BUTTONS-1:0] mask_q;
  logic                   irq_q;

  assign sel_mask = (i_wb_addr == BASE_ADDR + 32'h10);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && sel_mask) mask_q <= i_wb_data[NUM_BUTTONS-1:0];
      irq_q <= |(event_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign sel_mask = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata_mux = '0;
    if (sel_led) begin
      rdata_mux[NUM_LEDS-1:0] = led_out_q;
    end else if (sel_state) begin
      rdata_mux[NUM_BUTTONS-1:0] = state_q;
    end else if (sel_event) begin
      rdata_mux[NUM_BUTTONS-1:0] = event_q;
    end else if (sel_blink) begin
      rdata_mux[NUM_LEDS-1:0] = blink_q;
`ifdef WB_GPIO_IRQ_EN
    end else if (sel_mask) begin
      rdata_mux[NUM_BUTTONS-1:0] = mask_q;
`endif
    end
  end

  // Debounce: count consecutive mismatches between the synchronised level
  // and the accepted state; accept the level once the run is long enough.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          state_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // A new rise in the same cycle as a clear keeps the bit set.
  assign rise    = state_d & ~state_q;
  assign clr     = (wr && sel_event) ? i_wb_data[NUM_BUTTONS-1:0] : '0;
  assign event_d = (event_q & ~clr) | rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      led_out_q <= '0;
      blink_q   <= '0;
      leds_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= '0;
      event_q   <= '0;
      pre_q     <= '0;
      phase_q   <= 1'b0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      ack_q   <= req;
      rdata_q <= (req && !i_wb_we) ? rdata_mux : '0;
      if (wr && sel_led)   led_out_q <= i_wb_data[NUM_LEDS-1:0];
      if (wr && sel_blink) blink_q   <= i_wb_data[NUM_LEDS-1:0];
      sync1_q <= buttons;
      sync2_q <= sync1_q;
      state_q <= state_d;
      event_q <= event_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
      if (pre_q == PreLast) begin
        pre_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        pre_q <= pre_q + PreW'(1);
      end
      leds_q <= led_out_q ^ (blink_q & {NUM_LEDS{phase_q}});
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_data = rdata_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_wb_gpio_debounce.sv
// Self-checking bench for wb_gpio_debounce (DEBOUNCE_CYCLES=4, BLINK_DIV=8).
module tb_wb_gpio_debounce;

  localparam int unsigned NB = 3;
  localparam int unsigned NL = 8;
  localparam int unsigned DB = 4;
  localparam int unsigned BD = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic          ack;
  logic [31:0]   rdata;
  logic [NB-1:0] buttons = '0;
  logic [NL-1:0] leds;
  logic          irq;

  always #5 clk = ~clk;

  wb_gpio_debounce #(
    .BASE_ADDR      (BASE),
    .NUM_BUTTONS    (NB),
    .NUM_LEDS       (NL),
    .DEBOUNCE_CYCLES(DB),
    .BLINK_DIV      (BD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_wb_cyc (cyc),
    .i_wb_stb (stb),
    .i_wb_we  (we),
    .i_wb_addr(addr),
    .i_wb_data(wdata),
    .o_wb_ack (ack),
    .o_wb_data(rdata),
    .buttons  (buttons),
    .leds     (leds),
    .irq      (irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register values after the last edge, plus a history of
  // raw button samples. A button takes level v once the last DB synchronised
  // samples (raw delayed by two clocks) all equal v.
  logic          m_ack, m_irq;
  logic [31:0]   m_rdata;
  logic [NL-1:0] m_leds, m_led_out, m_blink;
  logic [NB-1:0] m_state, m_event, m_mask;
  int            m_k;
  logic [NB-1:0] hist[$];

  task automatic model_edge();
    logic          rq;
    logic [31:0]   rd;
    logic [NB-1:0] w_all, w_any, nstate, rise, clr, smp;
    logic [NL-1:0] nleds;
    logic          nirq, phase;
    if (!reset_n) begin
      m_ack = 0; m_rdata = 0; m_leds = 0; m_irq = 0; m_led_out = 0; m_blink = 0;
      m_state = 0; m_event = 0; m_mask = 0; m_k = 0;
      hist.delete();
      repeat (DB + 1) hist.push_back('0);
      return;
    end
    rq = cyc & stb & !m_ack;
    rd = 0;
    if (rq && !we) begin
      if (addr == BASE) rd = 32'(m_led_out);
      else if (addr == BASE + 32'h4) rd = 32'(m_state);
      else if (addr == BASE + 32'h8) rd = 32'(m_event);
      else if (addr == BASE + 32'hC) rd = 32'(m_blink);
`ifdef WB_GPIO_IRQ_EN
      else if (addr == BASE + 32'h10) rd = 32'(m_mask);
`endif
    end
    w_all = '1;
    w_any = '0;
    for (int j = 0; j < DB; j++) begin
      smp = hist[hist.size() - 2 - j];
      w_all &= smp;
      w_any |= smp;
    end
    nstate = m_state;
    for (int b = 0; b < NB; b++) begin
      if (!m_state[b] && w_all[b]) nstate[b] = 1'b1;
      else if (m_state[b] && !w_any[b]) nstate[b] = 1'b0;
    end
    rise  = nstate & ~m_state;
    clr   = (rq && we && addr == BASE + 32'h8) ? wdata[NB-1:0] : '0;
    phase = ((m_k / BD) % 2) == 1;
    nleds = m_led_out ^ (m_blink & {NL{phase}});
`ifdef WB_GPIO_IRQ_EN
    nirq = |(m_event & m_mask);
`else
    nirq = 1'b0;
`endif
    if (rq && we) begin
      if (addr == BASE) m_led_out = wdata[NL-1:0];
      if (addr == BASE + 32'hC) m_blink = wdata[NL-1:0];
`ifdef WB_GPIO_IRQ_EN
      if (addr == BASE + 32'h10) m_mask = wdata[NB-1:0];
`endif
    end
    m_event = (m_event & ~clr) | rise;
    m_state = nstate;
    m_ack   = rq;
    m_rdata = rd;
    m_leds  = nleds;
    m_irq   = nirq;
    m_k++;
    hist.push_back(buttons);
    if (hist.size() > DB + 2) void'(hist.pop_front());
  endtask

  // One clock: advance the model with the inputs the DUT is about to sample,
  // then compare all outputs just after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model_ack", ack, m_ack);
    check("model_rdata", rdata, m_rdata);
    check("model_leds", leds, m_leds);
    check("model_irq", irq, m_irq);
  endtask

  // Single wishbone transfer: request edge, then one idle edge so ack drops.
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] rd);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d;
    step();
    check("wb_ack_pulse", ack, 1);
    rd = rdata;
    cyc = 0; stb = 0; we = 0;
    step();
    check("wb_ack_drop", ack, 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] rd;
  logic [7:0]  prev;
  int          toggles;

  initial begin
    vecs.push_back('{0, BASE,            32'h0,        32'h0,  8'h00});
    vecs.push_back('{0, BASE + 32'h4,    32'h0,        32'h0,  8'h00});
    vecs.push_back('{0, BASE + 32'h8,    32'h0,        32'h0,  8'h00});
    vecs.push_back('{0, BASE + 32'hC,    32'h0,        32'h0,  8'h00});
    vecs.push_back('{1, BASE,            32'hFFFF_FFA5, 32'h0, 8'hA5});
    vecs.push_back('{0, BASE,            32'h0,        32'hA5, 8'hA5});
    vecs.push_back('{1, BASE + 32'h4,    32'hFF,       32'h0,  8'hA5});
    vecs.push_back('{0, BASE + 32'h4,    32'h0,        32'h0,  8'hA5});
    vecs.push_back('{0, BASE + 32'h14,   32'h0,        32'h0,  8'hA5});
    vecs.push_back('{1, BASE + 32'h1000, 32'h5A,       32'h0,  8'hA5});
    vecs.push_back('{0, BASE + 32'h1000, 32'h0,        32'h0,  8'hA5});
    vecs.push_back('{0, 32'h2000_0000,   32'h0,        32'h0,  8'hA5});

    // Reset state
    reset_n = 0;
    step();
    step();
    check("reset_leds", leds, 0);
    check("reset_ack", ack, 0);
    check("reset_rdata", rdata, 0);
    check("reset_irq", irq, 0);
    reset_n = 1;
    step();

    // Register access table
    foreach (vecs[i]) begin
      wb(vecs[i].we, vecs[i].addr, vecs[i].data, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_leds", i), leds, 32'(vecs[i].exp_leds));
    end

    // Held strobe is acked every second cycle
    cyc = 1; stb = 1; we = 0; addr = BASE;
    for (int i = 0; i < 4; i++) begin
      step();
      check("held_stb_ack", ack, (i % 2 == 0) ? 1 : 0);
      check("held_stb_data", rdata, (i % 2 == 0) ? 32'hA5 : 0);
    end
    cyc = 0; stb = 0;
    step();

    // Debounce latency and glitch rejection
    buttons = 3'b010;
    repeat (5) step();
    wb(0, BASE + 32'h4, 0, rd);
    check("btn_state_before", rd, 0);
    wb(0, BASE + 32'h4, 0, rd);
    check("btn_state_after", rd, 32'h2);
    wb(0, BASE + 32'h8, 0, rd);
    check("btn_event_set", rd, 32'h2);
    buttons = 3'b011;
    repeat (3) step();
    buttons = 3'b010;
    repeat (8) step();
    wb(0, BASE + 32'h4, 0, rd);
    check("glitch_state", rd, 32'h2);
    wb(0, BASE + 32'h8, 0, rd);
    check("glitch_event", rd, 32'h2);

    // Clear colliding with a new rise: set wins
    wb(1, BASE + 32'h8, 32'h2, rd);
    buttons = 3'b000;
    repeat (8) step();
    wb(0, BASE + 32'h8, 0, rd);
    check("event_cleared", rd, 0);
    buttons = 3'b010;
    repeat (5) step();
    wb(1, BASE + 32'h8, 32'h2, rd);
    wb(0, BASE + 32'h8, 0, rd);
    check("set_wins", rd, 32'h2);
    wb(1, BASE + 32'h8, 32'h2, rd);
    wb(0, BASE + 32'h8, 0, rd);
    check("event_clear_later", rd, 0);

    // Blink: LED_OUT=1, LED_BLINK=3 alternates 0x01/0x02 every BD clocks
    buttons = 3'b000;
    wb(1, BASE, 32'h1, rd);
    wb(1, BASE + 32'hC, 32'h3, rd);
    prev = leds;
    toggles = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      check("blink_value", (leds == 8'h01 || leds == 8'h02) ? 1 : 0, 1);
      if (leds != prev) toggles++;
      prev = leds;
    end
    check("blink_toggles", toggles, 4);

    // Reset mid-blink: leds clear and phase restarts at 0
    reset_n = 0;
    step();
    check("midblink_reset_leds", leds, 0);
    reset_n = 1;
    wb(1, BASE + 32'hC, 32'h1, rd);
    for (int i = 2; i <= 8; i++) begin
      check("phase0_leds", leds, 0);
      step();
    end
    check("phase1_leds", leds, 32'h1);
    wb(1, BASE + 32'hC, 32'h0, rd);
    check("blink_off_steady", leds, 0);

`ifdef WB_GPIO_IRQ_EN
    wb(1, BASE + 32'h10, 32'h1, rd);
    wb(0, BASE + 32'h10, 0, rd);
    check("mask_readback", rd, 32'h1);
    buttons = 3'b001;
    repeat (6) step();
    check("irq_same_edge", irq, 0);
    step();
    check("irq_next_clock", irq, 1);
    repeat (3) step();
    check("irq_held", irq, 1);
    wb(1, BASE + 32'h8, 32'h1, rd);
    check("irq_cleared", irq, 0);
`else
    wb(1, BASE + 32'h10, 32'h7, rd);
    wb(0, BASE + 32'h10, 0, rd);
    check("mask_unmapped", rd, 0);
    buttons = 3'b001;
    repeat (8) step();
    check("irq_tied_low", irq, 0);
`endif
    wb(0, BASE + 32'h14, 0, rd);
    check("unmapped_0x14", rd, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) buttons = NB'($urandom);
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 2) == 0);
      we  = $urandom_range(0, 1);
      if ($urandom_range(0, 6) == 6) addr = $urandom;
      else addr = BASE + 32'(4 * $urandom_range(0, 5));
      wdata = $urandom;
      reset_n = !(i == 700);
      step();
    end
    reset_n = 1;
    cyc = 0; stb = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
